// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex seven-segment driver: digit register file, prescaled scan, hex decode and
// registered anode/segment outputs. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned PRESCALE       = 1000,
   parameter bit          SEG_ACTIVE_LOW = 1'b0,
   parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  wr_en,
   input  logic [2:0]            wr_addr,
   input  logic [3:0]            wr_data,
   input  logic                  wr_dp,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [NUM_DIGITS-1:0] an_o
);

   localparam int unsigned IdxW = $clog2(NUM_DIGITS);
   localparam int unsigned CntW = $clog2(PRESCALE);

   logic [3:0]            digValQ [NUM_DIGITS];
   logic                  digDpQ  [NUM_DIGITS];
   logic [CntW-1:0]       preCntQ, preCntD;
   logic [IdxW-1:0]       idxQ, idxD;
   logic [NUM_DIGITS-1:0] anQ, anD;
   logic [6:0]            segQ, segD;
   logic                  dpQ, dpD;
   logic                  wrHit;
   logic                  blank;

   function automatic logic [6:0] hexDecode(input logic [3:0] v);
      logic [6:0] s;
      s = 7'h00;
      unique case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
      endcase
      return s;
   endfunction

   // Out-of-range addresses are dropped rather than aliased onto a real digit.
   assign wrHit = wr_en && (32'(wr_addr) < NUM_DIGITS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            digValQ[i] <= 4'h0;
            digDpQ[i]  <= 1'b0;
         end
      end else if (wrHit) begin
         digValQ[wr_addr[IdxW-1:0]] <= wr_data;
         digDpQ[wr_addr[IdxW-1:0]]  <= wr_dp;
      end
   end

   always_comb begin
      preCntD = preCntQ;
      idxD    = idxQ;
      if (en) begin
         if (preCntQ == CntW'(PRESCALE - 1)) begin
            preCntD = '0;
            idxD    = (idxQ == IdxW'(NUM_DIGITS - 1)) ? '0 : idxQ + IdxW'(1);
         end else begin
            preCntD = preCntQ + CntW'(1);
         end
      end
   end

`ifdef SEG7_LZB_EN
   logic [NUM_DIGITS-1:0] zeroFrom;

   // zeroFrom[i]: digit i and every higher-index digit hold zero.
   always_comb begin
      logic z;
      z        = 1'b1;
      zeroFrom = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         z = 1'b1;
         for (int j = i; j < int'(NUM_DIGITS); j++) begin
            if (digValQ[j] != 4'h0) z = 1'b0;
         end
         zeroFrom[i] = z;
      end
   end

   assign blank = (idxQ != '0) && zeroFrom[idxQ];
`else
   assign blank = 1'b0;
`endif

   // First cycle of each digit period keeps anodes off to avoid ghosting.
   always_comb begin
      anD  = '0;
      segD = 7'h00;
      dpD  = 1'b0;
      if (en) begin
         if (preCntQ != '0) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
               anD[i] = (idxQ == IdxW'(i));
            end
         end
         segD = blank ? 7'h00 : hexDecode(digValQ[idxQ]);
         dpD  = digDpQ[idxQ];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preCntQ <= '0;
         idxQ    <= '0;
         anQ     <= '0;
         segQ    <= 7'h00;
         dpQ     <= 1'b0;
      end else begin
         preCntQ <= preCntD;
         idxQ    <= idxD;
         anQ     <= anD;
         segQ    <= segD;
         dpQ     <= dpD;
      end
   end

   assign an_o  = anQ ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
   assign seg_o = segQ ^ {7{SEG_ACTIVE_LOW}};
   assign dp_o  = dpQ ^ SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: active-high and active-low instances share stimulus and
// are checked against a cycle-count reference model. Honours SEG7_LZB_EN like the design.
module tb_seg7_scan_driver;

   localparam int N = 4;
   localparam int P = 4;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic       wr_dp;
   logic [6:0] segH, segL;
   logic       dpH, dpL;
   logic [3:0] anH, anL;

   int checks = 0;
   int errors = 0;

   exp_t       sb [$];
   exp_t       mon;
   int         t;
   logic [3:0] mVal [N];
   logic       mDp  [N];
   logic [6:0] decTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg7_scan_driver #(
      .NUM_DIGITS(N), .PRESCALE(P), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
   ) dutH (
      .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_dp(wr_dp), .seg_o(segH), .dp_o(dpH), .an_o(anH)
   );

   seg7_scan_driver #(
      .NUM_DIGITS(N), .PRESCALE(P), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dutL (
      .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_dp(wr_dp), .seg_o(segL), .dp_o(dpL), .an_o(anL)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
      end
   endtask

   // Display state follows from the number of enabled cycles t since reset.
   function automatic exp_t predict(input logic e);
      exp_t r;
      int   pos, d, ph;
      bit   blank;
      r   = '0;
      pos = t % (N * P);
      d   = pos / P;
      ph  = pos % P;
      if (e) begin
         if (ph != 0) r.an = 4'(1 << d);
         blank = 1'b0;
`ifdef SEG7_LZB_EN
         if (d > 0) begin
            blank = 1'b1;
            for (int j = d; j < N; j++) if (mVal[j] != 4'h0) blank = 1'b0;
         end
`endif
         r.seg = blank ? 7'h00 : decTab[mVal[d]];
         r.dp  = mDp[d];
      end
      return r;
   endfunction

   task automatic step(input logic e, input logic w, input logic [2:0] a, input logic [3:0] d,
                       input logic p);
      int ai;
      @(negedge clk);
      en      = e;
      wr_en   = w;
      wr_addr = a;
      wr_data = d;
      wr_dp   = p;
      sb.push_back(predict(e));
      ai = int'(a);
      if (w && ai < N) begin
         mVal[ai] = d;
         mDp[ai]  = p;
      end
      if (e) t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 4'h0, 1'b0);
   endtask

   task automatic modelReset();
      t = 0;
      for (int i = 0; i < N; i++) begin
         mVal[i] = 4'h0;
         mDp[i]  = 1'b0;
      end
   endtask

   task automatic checkResetPins(input string tag);
      check({tag, "_anH"}, {4'b0, anH}, 8'h00);
      check({tag, "_segH"}, {1'b0, segH}, 8'h00);
      check({tag, "_dpH"}, {7'b0, dpH}, 8'h00);
      check({tag, "_anL"}, {4'b0, anL}, 8'h0F);
      check({tag, "_segL"}, {1'b0, segL}, 8'h7F);
      check({tag, "_dpL"}, {7'b0, dpL}, 8'h01);
   endtask

   // Reset lands between edges so the pins must change with no clock.
   task automatic asyncReset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      en    = 1'b0;
      wr_en = 1'b0;
      #1;
      checkResetPins("asyncRst");
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      #2;
      if (rst_n && sb.size() > 0) begin
         mon = sb.pop_front();
         check("anH", {4'b0, anH}, {4'b0, mon.an});
         check("segH", {1'b0, segH}, {1'b0, mon.seg});
         check("dpH", {7'b0, dpH}, {7'b0, mon.dp});
         check("anL", {4'b0, anL}, {4'b0, ~mon.an});
         check("segL", {1'b0, segL}, {1'b0, ~mon.seg});
         check("dpL", {7'b0, dpL}, {7'b0, ~mon.dp});
      end
   end

   initial begin
      rst_n   = 1'b1;
      en      = 1'b0;
      wr_en   = 1'b0;
      wr_addr = 3'd0;
      wr_data = 4'h0;
      wr_dp   = 1'b0;
      modelReset();
      #1 rst_n = 1'b0;
      #1 checkResetPins("initRst");
      @(negedge clk);
      rst_n = 1'b1;

      // Scan digits 1,2,3,4 over two frames, loaded while dark.
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, 3'(i), 4'(i + 1), 1'b0);
      idle(2 * N * P);

      // Decode sweep on digit 0, then an out-of-range write that must change nothing.
      for (int v = 0; v < 16; v++) begin
         step(1'b1, 1'b1, 3'd0, 4'(v), 1'(v & 1));
         idle(N * P - 1);
      end
      step(1'b1, 1'b1, 3'd5, 4'($urandom_range(0, 15)), 1'b1);
      idle(N * P);

      // Live update of digit 2 while it is displayed.
      for (int i = 0; i < 2 * N * P; i++) begin
         if ((t % (N * P)) / P == 2 && (t % P) == 2) break;
         idle(1);
      end
      step(1'b1, 1'b1, 3'd2, 4'hE, 1'b1);
      idle(6);

      // Enable dropped mid-digit, then resumed.
      idle(5);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 3'd0, 4'h0, 1'b0);
      idle(N * P);

      // Reset mid-scan, then restart from a clean state.
      asyncReset();
      idle(2 * P + 2);

      // Leading-zero pattern {3:0} = 0,0,7,0.
      step(1'b1, 1'b1, 3'd0, 4'h0, 1'b0);
      step(1'b1, 1'b1, 3'd1, 4'h7, 1'b0);
      step(1'b1, 1'b1, 3'd2, 4'h0, 1'b1);
      step(1'b1, 1'b1, 3'd3, 4'h0, 1'b0);
      idle(2 * N * P);

      for (int i = 0; i < 1500; i++) begin
         if (i == 700) asyncReset();
         step(1'(($urandom % 8) != 0), 1'($urandom % 2), 3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)), 1'($urandom % 2));
      end

      @(negedge clk);
      @(negedge clk);
      check("sbEmpty", 8'(sb.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed hex seven-segment display driver that generalises our single-digit OR-tree segment decode to NUM_DIGITS digits. Holds a writable digit register file, scans digits with a prescaled counter, decodes 4-bit values to hex segment patterns, and drives registered segment and anode outputs with configurable polarity. It sits between user logic (writes digit values) and the board's multiplexed display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- PRESCALE, 1000, clock cycles each digit is selected (min 2)
- SEG_ACTIVE_LOW, 0, 1 = segment/dp outputs active low
- AN_ACTIVE_LOW, 0, 1 = anode outputs active low

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; low = display dark, scan frozen
- wr_en  in  1  write strobe, one write per cycle
- wr_addr  in  3  digit index written (0 = least significant)
- wr_data  in  4  hex value for the digit
- wr_dp  in  1  decimal point for the digit
- seg_o  out  7  segments, bit0=a … bit6=g
- dp_o  out  1  decimal point
- an_o  out  NUM_DIGITS  one-hot digit select

## Operation
- Digit file: NUM_DIGITS entries of {value[3:0], dp}. On wr_en with wr_addr < NUM_DIGITS, entry updates at that edge; wr_addr ≥ NUM_DIGITS ignored.
- Prescaler pre_cnt counts 0..PRESCALE-1 while en=1; at PRESCALE-1 it wraps to 0 and digit index idx advances; idx wraps NUM_DIGITS-1 → 0.
- en=0: pre_cnt and idx hold; next output register load drives all anodes, segments and dp inactive. Digit writes still accepted.
- Decode (hex, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Output register (loaded every cycle): an_o ← 0 if pre_cnt==0 or en=0, else onehot(idx); seg_o/dp_o ← decode/dp of entry idx (inactive when en=0). Polarity inversion applied after, per parameters.
- Dead time: pre_cnt==0 blanking gives exactly one anodes-off cycle per digit period, preventing ghosting.

## Timing
- Reset (async assert, sync release): digit file all {0,0}, pre_cnt=0, idx=0; an_o all inactive, seg_o and dp_o inactive (all 0, or all 1 for active-low).
- Output latency: 1 cycle from pre_cnt/idx/digit-file state to pins.
- Write at edge k to displayed digit → seg_o shows new pattern after edge k+1.
- Write and scan advance in same cycle: both take effect; no hazard.
- Digit period exactly PRESCALE cycles: 1 cycle anodes off, PRESCALE-1 cycles digit on. Full frame = NUM_DIGITS×PRESCALE cycles.
- en falling at edge k: pins inactive after edge k+1; en rising: scan resumes from held pre_cnt/idx.
- Reset asserted mid-scan: all state and pins return to reset values immediately, without clock.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking. Digit i (i>0) shows segments off when its value and all higher-index values are 0; dp still shown; digit 0 never blanked. Anode timing unchanged.
- Undefined: every digit always shows its decoded value (zeros drawn as 3F).

## Test plan
- Reset: assert rst_n=0 mid-scan with no clock → an_o=0, seg_o=00, dp_o=0 at once; after release with en=1, PRESCALE=4, an_o=0001 from cycle 2 for 3 cycles.
- Scan: NUM_DIGITS=4, PRESCALE=4, digits 1,2,3,4 → per period one blank cycle, then an_o=0001/seg_o=06, 0010/5B, 0100/4F, 1000/66; wrap to 0001.
- Decode sweep: write 0..F to digit 0 → seg_o matches table for each; wr_addr=5 write leaves all digits unchanged.
- Live update: write digit 2 = E with dp while it is displayed → seg_o=79, dp_o=1 one cycle later.
- Enable/polarity: SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, drop en → an_o=1111, seg_o=7F; pre_cnt/idx frozen, scan resumes at same digit.
- SEG7_LZB_EN: digits {3:0}=0,0,7,0 → digit3 seg off, digit2 off, digit1=07, digit0=3F; without macro digits 3 and 2 show 3F.
